// File: rtl/simptel_pkg.sv
// Shared types for the memory arbiter: FSM state, port owner encoding, bus width defaults.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package simptel_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic {
        CPU = 1'b0,
        LDR = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_arbiter_arb_pick.sv
// Two-way winner select between the CPU and loader request lines.
// Latency: combinational.
// Backpressure: none; the loser simply keeps its request held until a later grant.
// Optional feature: MEM_ARB_ROUND_ROBIN_EN selects round-robin ties, otherwise CPU has fixed priority.
module arb_pick
    import simptel_pkg::*;
(
    input  logic   cpu_req,
    input  logic   ldr_req,
    input  owner_t last_served,
    output logic   any_req,
    output owner_t pick
);

`ifndef MEM_ARB_ROUND_ROBIN_EN
    // Fixed priority ignores the history flag.
    logic unused_last;
    assign unused_last = last_served;
`endif

    // Select the winner; a lone requester always wins, ties depend on the build.
    always_comb begin
        any_req = cpu_req | ldr_req;
        pick    = CPU;
        if (cpu_req && ldr_req) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            pick = (last_served == CPU) ? LDR : CPU;
`else
            pick = CPU;
`endif
        end else if (ldr_req) begin
            pick = LDR;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a CPU port and a program-loader port onto one fixed-latency memory.
// Latency: request sampled at edge N -> ack pulses in cycle N+MEM_LAT+1; mem_en high MEM_LAT cycles.
// Backpressure: one transaction in flight; requests are ignored in BUSY/DONE and the loser holds req.
// Optional feature: MEM_ARB_ROUND_ROBIN_EN (round-robin tie break; fixed CPU priority when undefined).
module mem_arbiter
    import simptel_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int MEM_LAT = 1            // legal 1..7; 0 is not supported
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    output logic              cpu_stall,
    input  logic              ldr_req,
    input  logic              ldr_we,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [DATA_W-1:0] ldr_wdata,
    output logic [DATA_W-1:0] ldr_rdata,
    output logic              ldr_ack,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_t            state_q, state_d;
    owner_t            owner_q, owner_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] ldr_rdata_q, ldr_rdata_d;
    owner_t            last_q, last_d;
    logic              any_req;
    owner_t            pick;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // Remember who was granted last so the next tie goes the other way.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) last_q <= LDR;
        else       last_q <= last_d;
    end
`else
    // No history is kept under fixed priority.
    always_comb last_q = LDR;
`endif

    arb_pick u_pick (
        .cpu_req     (cpu_req),
        .ldr_req     (ldr_req),
        .last_served (last_q),
        .any_req     (any_req),
        .pick        (pick)
    );

    // Grant, count down the memory access, capture read data, then one DONE cycle for the ack.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cpu_rdata_d = cpu_rdata_q;
        ldr_rdata_d = ldr_rdata_q;
        last_d      = last_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    owner_d = pick;
                    last_d  = pick;
                    state_d = BUSY;
                    cnt_d   = 3'(MEM_LAT - 1);
                    if (pick == CPU) begin
                        we_d    = cpu_we;
                        addr_d  = cpu_addr;
                        wdata_d = cpu_wdata;
                    end else begin
                        we_d    = ldr_we;
                        addr_d  = ldr_addr;
                        wdata_d = ldr_wdata;
                    end
                end
            end
            BUSY: begin
                if (cnt_q == 3'd0) begin
                    state_d = DONE;
                    if (!we_q) begin
                        if (owner_q == CPU) cpu_rdata_d = mem_rdata;
                        else                ldr_rdata_d = mem_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset drops any in-flight transaction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            owner_q     <= CPU;
            cnt_q       <= 3'd0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cpu_rdata_q <= '0;
            ldr_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cpu_rdata_q <= cpu_rdata_d;
            ldr_rdata_q <= ldr_rdata_d;
        end
    end

    // Memory is only enabled in BUSY; address/data keep the last latched values otherwise.
    always_comb begin
        mem_en    = (state_q == BUSY);
        mem_we    = (state_q == BUSY) && we_q;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        cpu_ack   = (state_q == DONE) && (owner_q == CPU);
        ldr_ack   = (state_q == DONE) && (owner_q == LDR);
        cpu_stall = cpu_req && !cpu_ack;
        cpu_rdata = cpu_rdata_q;
        ldr_rdata = ldr_rdata_q;
    end

endmodule
